hamming_secded_codec: RTL and testbench
=======================================

# hamming_secded_codec

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) codec for the dual-port memory datapath. It replaces the fixed 8→12 combinational encoder with two independent channels. The encode channel protects write data on its way into the memory array. The decode channel checks, corrects and classifies read data coming out of it. Both channels use valid/ready handshakes, and the block keeps saturating error-statistics counters.

## Interface
- `DATA_W`, 8, data word width (≥4).
- `CNT_W`, 16, width of each error counter.
- Derived (localparam): `P` = smallest integer with 2^P ≥ DATA_W+P+1; `CODE_W` = DATA_W+P+1. DATA_W=8 gives P=4, CODE_W=13; DATA_W=32 gives P=6, CODE_W=39.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enc_in_valid` / `enc_in_ready`  in / out  1  encode input handshake.
- `enc_data`  in  DATA_W  data to encode.
- `enc_out_valid` / `enc_out_ready`  out / in  1  encode output handshake.
- `enc_code`  out  CODE_W  codeword.
- `dec_in_valid` / `dec_in_ready`  in / out  1  decode input handshake.
- `dec_code`  in  CODE_W  codeword read from memory.
- `dec_out_valid` / `dec_out_ready`  out / in  1  decode output handshake.
- `dec_data`  out  DATA_W  corrected data.
- `dec_syndrome`  out  P  Hamming syndrome.
- `dec_sec`  out  1  single error detected and corrected.
- `dec_ded`  out  1  double error detected; data not corrected.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `sec_count`, `ded_count`  out  CNT_W  saturating error counters.

## Operation
- **Codeword layout.** Hamming positions 1..DATA_W+P map to `code[pos-1]`.
  - Parity bit p_k sits at position 2^k.
  - Data bits fill the remaining positions in ascending order, `data[0]` at the lowest (position 3).
  - p_k is the even-parity XOR of every position whose index has bit k set.
  - `code[CODE_W-1]` is the overall even parity of `code[CODE_W-2:0]`.
- **Encode channel.** One register stage. It captures on `enc_in_valid && enc_in_ready` and holds its output stable until `enc_out_ready`.
- **Decode channel, stage 1.** Registers the syndrome S (recomputed parity XOR received parity, P bits) and the overall parity check O (XOR of all CODE_W received bits), together with the codeword.
- **Decode channel, stage 2.** Registers the result:
  - S=0, O=0: clean. Flags 0, data extracted unchanged.
  - O=1: single error at position S. S=0 means the overall parity bit itself is in error. `dec_sec`=1, bit `code[S-1]` is flipped before data extraction (no flip when S=0).
  - S≠0, O=0: double error. `dec_ded`=1, data extracted from the uncorrected word.
  - O=1 with S > DATA_W+P (impossible position): treat as `dec_ded`=1, no correction.
  - `dec_syndrome` = S in every case.
- **Counters.** Increment on each decode output transfer (`dec_out_valid && dec_out_ready`): `sec_count` when `dec_sec`, `ded_count` when `dec_ded`.
  - Both saturate at 2^CNT_W−1.
  - `cnt_clr` forces both to 0; clear wins over a simultaneous increment.
- **Channel independence.** The two channels operate fully concurrently with no shared state.

## Timing
- **Reset.** While `rst_n`=0 at a rising edge:
  - All valids go to 0, and all data/code/syndrome/flag registers go to 0.
  - Counters go to 0.
  - In-flight words are discarded and not counted.
  - During reset the `*_in_ready` outputs are driven 1, since the stages are empty.
- **Encode latency.** 1 cycle: a word accepted at edge N is valid on `enc_code` after edge N.
- **Decode latency.** 2 cycles, input transfer to `dec_out_valid`.
- **Stage acceptance.** A stage loads when it is empty or its contents leave the same cycle:
  - Each `*_in_ready` is combinational.
  - `enc_in_ready` = !enc_out_valid || enc_out_ready.
  - `dec_in_ready` = !s1_valid || s2 can accept.
  - s2 can accept = !dec_out_valid || dec_out_ready.
- **Throughput.** Full, one word per cycle per channel, with back-to-back transfers and no bubbles.
- **Backpressure.** Outputs and flags hold stable while valid && !ready. No word is dropped or duplicated.
- **Valid semantics.** Valid never depends on ready. An input word is consumed only on the valid && ready cycle.

## Test plan
- **Encode.** Encode 8'h00 → `enc_code`=13'h0000; encode 8'hFF → 13'h0F77; each appears 1 cycle after acceptance.
- **Single-error correction.** Decode 13'h0F67 (bit 4 / position 5 flipped) → `dec_data`=8'hFF, `dec_syndrome`=5, `dec_sec`=1, `dec_ded`=0, 2 cycles after input; `sec_count` increments 0→1 on the output transfer.
- **Double-error detection.** Decode 13'h0F74 (bits 0 and 1 flipped) → `dec_syndrome`=3, `dec_ded`=1, `dec_sec`=0, `dec_data`=8'hFF (uncorrected data bits unaffected); `ded_count`=1. Decode 13'h1F77 (overall parity bit flipped) → `dec_sec`=1, `dec_syndrome`=0, data 8'hFF.
- **Throughput and backpressure.** Stream 100 random words through encode then decode, randomly deasserting `dec_out_ready`/`enc_out_ready` → every word returns in order and bit-exact with no flags, zero loss, and one word per cycle when ready is held high.
- **Counter saturation and clear.** With CNT_W=2, inject 5 single errors → `sec_count` saturates at 3. Assert `cnt_clr` in the same cycle as an increment → count reads 0.
- **Reset mid-operation.** Assert `rst_n`=0 with both decode stages full → next cycle valids are 0, counters 0 and `dec_in_ready`=1; no stale word emerges after release.

Source files
------------

// File: rtl/hamming_secded_codec.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_codec
// Purpose  : Pipelined Hamming SECDED encoder (1 stage) and decoder (2 stages)
//            with valid/ready handshakes and saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_secded_codec #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int P_LO   = $clog2(DATA_W + 1),
    localparam int P      = ((1 << P_LO) >= DATA_W + P_LO + 1) ? P_LO : P_LO + 1,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_in_valid,
    output logic              enc_in_ready,
    input  logic [DATA_W-1:0] enc_data,
    output logic              enc_out_valid,
    input  logic              enc_out_ready,
    output logic [CODE_W-1:0] enc_code,
    input  logic              dec_in_valid,
    output logic              dec_in_ready,
    input  logic [CODE_W-1:0] dec_code,
    output logic              dec_out_valid,
    input  logic              dec_out_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic [P-1:0]      dec_syndrome,
    output logic              dec_sec,
    output logic              dec_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count
);

    localparam int              HAM_N   = DATA_W + P;
    localparam logic [P-1:0]    MAX_POS = HAM_N[P-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Hamming positions 1..HAM_N live at code[pos-1]; powers of two hold parity.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] code;
        int                di;
        code = '0;
        di   = 0;
        for (int pos = 1; pos <= HAM_N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                code[pos-1] = data[di];
                di++;
            end
        end
        for (int k = 0; k < P; k++) begin
            for (int pos = 1; pos <= HAM_N; pos++) begin
                if (pos[k] && ((pos & (pos - 1)) != 0)) begin
                    code[(1 << k) - 1] ^= code[pos-1];
                end
            end
        end
        code[CODE_W-1] = ^code[CODE_W-2:0];
        return code;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] data;
        int                di;
        data = '0;
        di   = 0;
        for (int pos = 1; pos <= HAM_N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data[di] = code[pos-1];
                di++;
            end
        end
        return data;
    endfunction

    // Covering the parity position too yields recomputed XOR received parity.
    function automatic logic [P-1:0] syndrome(input logic [CODE_W-1:0] code);
        logic [P-1:0] s;
        s = '0;
        for (int k = 0; k < P; k++) begin
            for (int pos = 1; pos <= HAM_N; pos++) begin
                if (pos[k]) begin
                    s[k] ^= code[pos-1];
                end
            end
        end
        return s;
    endfunction

    // ---------------------------------------------------------------- encode
    logic              r_enc_valid;
    logic [CODE_W-1:0] r_enc_code;

    assign enc_in_ready  = !rst_n || !r_enc_valid || enc_out_ready;
    assign enc_out_valid = r_enc_valid;
    assign enc_code      = r_enc_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_enc_valid <= 1'b0;
            r_enc_code  <= '0;
        end else if (enc_in_ready) begin
            r_enc_valid <= enc_in_valid;
            if (enc_in_valid) begin
                r_enc_code <= encode(enc_data);
            end
        end
    end

    // ---------------------------------------------------------------- decode
    logic              r_s1_valid;
    logic [CODE_W-1:0] r_s1_code;
    logic [P-1:0]      r_s1_syn;
    logic              r_s1_ovr;
    logic              r_dec_valid;
    logic [DATA_W-1:0] r_dec_data;
    logic [P-1:0]      r_dec_syn;
    logic              r_dec_sec;
    logic              r_dec_ded;
    logic              w_s2_accept;

    assign w_s2_accept   = !r_dec_valid || dec_out_ready;
    assign dec_in_ready  = !rst_n || !r_s1_valid || w_s2_accept;
    assign dec_out_valid = r_dec_valid;
    assign dec_data      = r_dec_data;
    assign dec_syndrome  = r_dec_syn;
    assign dec_sec       = r_dec_sec;
    assign dec_ded       = r_dec_ded;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_ovr   <= 1'b0;
        end else if (dec_in_ready) begin
            r_s1_valid <= dec_in_valid;
            if (dec_in_valid) begin
                r_s1_code <= dec_code;
                r_s1_syn  <= syndrome(dec_code);
                r_s1_ovr  <= ^dec_code;
            end
        end
    end

    logic              w_bad_pos;
    logic              w_sec;
    logic              w_ded;
    logic [CODE_W-1:0] w_fixed;

    // A syndrome beyond the last position cannot be a single error.
    always_comb begin
        w_bad_pos = (r_s1_syn > MAX_POS);
        w_sec     = r_s1_ovr && !w_bad_pos;
        w_ded     = (!r_s1_ovr && (r_s1_syn != '0)) || (r_s1_ovr && w_bad_pos);
        w_fixed   = r_s1_code;
        if (w_sec) begin
            for (int pos = 1; pos <= HAM_N; pos++) begin
                if (r_s1_syn == pos[P-1:0]) begin
                    w_fixed[pos-1] = ~r_s1_code[pos-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
            r_dec_syn   <= '0;
            r_dec_sec   <= 1'b0;
            r_dec_ded   <= 1'b0;
        end else if (w_s2_accept) begin
            r_dec_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dec_data <= extract(w_fixed);
                r_dec_syn  <= r_s1_syn;
                r_dec_sec  <= w_sec;
                r_dec_ded  <= w_ded;
            end
        end
    end

    // -------------------------------------------------------------- counters
    logic r_sec_cnt_unused;
    logic [CNT_W-1:0] r_sec_count;
    logic [CNT_W-1:0] r_ded_count;
    logic             w_dec_xfer;

    assign w_dec_xfer       = r_dec_valid && dec_out_ready;
    assign sec_count        = r_sec_count;
    assign ded_count        = r_ded_count;
    assign r_sec_cnt_unused = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_sec_count <= '0;
            r_ded_count <= '0;
        end else if (w_dec_xfer) begin
            if (r_dec_sec && (r_sec_count != CNT_MAX)) begin
                r_sec_count <= r_sec_count + 1'b1;
            end
            if (r_dec_ded && (r_ded_count != CNT_MAX)) begin
                r_ded_count <= r_ded_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_codec.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_secded_codec
// Purpose  : Scoreboard bench for hamming_secded_codec (DATA_W=8, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_codec;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] syn;
        logic       sec;
        logic       ded;
    } dec_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_in_valid, enc_in_ready, enc_out_valid, enc_out_ready;
    logic [7:0]  enc_data;
    logic [12:0] enc_code;
    logic        dec_in_valid, dec_in_ready, dec_out_valid, dec_out_ready;
    logic [12:0] dec_code;
    logic [7:0]  dec_data;
    logic [3:0]  dec_syndrome;
    logic        dec_sec, dec_ded;
    logic        cnt_clr;
    logic [1:0]  sec_count, ded_count;

    // In chain mode the encoder output feeds the decoder input directly.
    logic        chain, gate, rand_ready;
    logic        tb_dec_valid, tb_enc_ready;
    logic [12:0] tb_dec_code;

    assign dec_in_valid  = chain ? (enc_out_valid && gate) : tb_dec_valid;
    assign dec_code      = chain ? enc_code : tb_dec_code;
    assign enc_out_ready = chain ? (dec_in_ready && gate) : tb_enc_ready;

    always #5 clk = ~clk;

    hamming_secded_codec #(.DATA_W(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_data(enc_data),
        .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_code(enc_code),
        .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_code(dec_code),
        .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_data(dec_data),
        .dec_syndrome(dec_syndrome), .dec_sec(dec_sec), .dec_ded(dec_ded),
        .cnt_clr(cnt_clr), .sec_count(sec_count), .ded_count(ded_count)
    );

    logic [12:0] enc_q[$];
    dec_exp_t    dec_q[$];
    int          total = 0;
    int          bad   = 0;
    int          dec_outs = 0;
    int          enc_outs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks that
    // stalled outputs stay frozen.
    initial begin : monitor
        logic        hold_e, hold_d;
        logic [12:0] held_e;
        logic [13:0] held_d;
        dec_exp_t    e;
        hold_e = 1'b0;
        hold_d = 1'b0;
        held_e = '0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (hold_e) check("enc_hold", {enc_out_valid, enc_code}, {1'b1, held_e});
                if (hold_d) check("dec_hold", {dec_out_valid, dec_data, dec_syndrome, dec_sec, dec_ded},
                                  {1'b1, held_d});
                if (enc_out_valid && enc_out_ready && !chain) begin
                    enc_outs++;
                    if (enc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL enc_unexpected: got code 0x%0h, expected no output", enc_code);
                    end else begin
                        check("enc_code", enc_code, enc_q.pop_front());
                    end
                end
                if (dec_out_valid && dec_out_ready) begin
                    dec_outs++;
                    if (dec_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dec_unexpected: got data 0x%0h, expected no output", dec_data);
                    end else begin
                        e = dec_q.pop_front();
                        check("dec_out", {dec_data, dec_syndrome, dec_sec, dec_ded}, e);
                    end
                end
            end
            hold_e = (rst_n === 1'b1) && enc_out_valid && !enc_out_ready;
            hold_d = (rst_n === 1'b1) && dec_out_valid && !dec_out_ready;
            held_e = enc_code;
            held_d = {dec_data, dec_syndrome, dec_sec, dec_ded};
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            gate          = ($urandom_range(0, 3) != 0);
            dec_out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_enc(input logic [7:0] d, output int waits);
        logic acc;
        enc_in_valid = 1'b1;
        enc_data     = d;
        waits        = 0;
        do begin
            @(negedge clk);
            acc = enc_in_ready;
            tick();
            if (!acc) waits++;
        end while (!acc && waits < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL enc_accept: got no acceptance, expected handshake within 200 cycles");
        end
        enc_in_valid = 1'b0;
    endtask

    task automatic send_dec(input logic [12:0] c);
        logic acc;
        int   waits;
        tb_dec_valid = 1'b1;
        tb_dec_code  = c;
        waits        = 0;
        do begin
            @(negedge clk);
            acc = dec_in_ready;
            tick();
            waits++;
        end while (!acc && waits < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL dec_accept: got no acceptance, expected handshake within 200 cycles");
        end
        tb_dec_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int w;
        for (w = 0; w < limit && (dec_q.size() != 0 || enc_q.size() != 0); w++) tick();
        tick();
        check("drain", dec_q.size() + enc_q.size(), 0);
    endtask

    // Directed decode: push expectation, check two-stage latency, then counters.
    task automatic dec_vec(input logic [12:0] c, input logic [7:0] d, input logic [3:0] s,
                           input logic sec, input logic ded,
                           input logic [1:0] exp_sec_cnt, input logic [1:0] exp_ded_cnt);
        dec_q.push_back('{data: d, syn: s, sec: sec, ded: ded});
        send_dec(c);
        check("dec_lat_s1", dec_out_valid, 1'b0);
        tick();
        check("dec_lat_s2", dec_out_valid, 1'b1);
        drain(20);
        check("sec_count", sec_count, exp_sec_cnt);
        check("ded_count", ded_count, exp_ded_cnt);
    endtask

    initial begin : main
        int waits;
        int stalls;
        int outs_before;
        int enc_before;
        logic [7:0] w;
        rst_n = 1'b0;  cnt_clr = 1'b0;  chain = 1'b0;  gate = 1'b1;  rand_ready = 1'b0;
        enc_in_valid = 1'b0;  enc_data = '0;  tb_enc_ready = 1'b1;
        tb_dec_valid = 1'b0;  tb_dec_code = '0;  dec_out_ready = 1'b1;
        repeat (3) tick();
        check("rst_enc_valid", enc_out_valid, 1'b0);
        check("rst_dec_valid", dec_out_valid, 1'b0);
        check("rst_enc_ready", enc_in_ready, 1'b1);
        check("rst_dec_ready", dec_in_ready, 1'b1);
        check("rst_counts", {sec_count, ded_count}, 4'h0);
        rst_n = 1'b1;
        tick();

        // Encode with one-cycle latency.
        enc_q.push_back(13'h0000);
        send_enc(8'h00, waits);
        check("enc_lat_00", enc_out_valid, 1'b1);
        drain(10);
        enc_q.push_back(13'h0F77);
        send_enc(8'hFF, waits);
        check("enc_lat_ff", enc_out_valid, 1'b1);
        drain(10);

        // Decode classification: single, double, overall-parity, clean, impossible position.
        dec_vec(13'h0F67, 8'hFF, 4'd5,  1'b1, 1'b0, 2'd1, 2'd0);
        dec_vec(13'h0F74, 8'hFF, 4'd3,  1'b0, 1'b1, 2'd1, 2'd1);
        dec_vec(13'h1F77, 8'hFF, 4'd0,  1'b1, 1'b0, 2'd2, 2'd1);
        dec_vec(13'h0F77, 8'hFF, 4'd0,  1'b0, 1'b0, 2'd2, 2'd1);
        dec_vec(13'h0089, 8'h00, 4'd13, 1'b0, 1'b1, 2'd2, 2'd2);
        dec_vec(13'h0800, 8'h00, 4'd12, 1'b1, 1'b0, 2'd3, 2'd2);

        // Saturation at 3 and clear-over-increment.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_counts", {sec_count, ded_count}, 4'h0);
        for (int i = 0; i < 5; i++) begin
            dec_q.push_back('{data: 8'h00, syn: 4'd1, sec: 1'b1, ded: 1'b0});
            send_dec(13'h0001);
        end
        drain(30);
        check("sec_saturate", sec_count, 2'd3);
        check("ded_after_clr", ded_count, 2'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        dec_out_ready = 1'b0;
        dec_q.push_back('{data: 8'h00, syn: 4'd2, sec: 1'b1, ded: 1'b0});
        send_dec(13'h0002);
        tick();
        tick();
        check("stall_valid", dec_out_valid, 1'b1);
        cnt_clr       = 1'b1;
        dec_out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_wins", sec_count, 2'd0);
        drain(10);

        // Reset with both decode stages and the encoder stage full.
        dec_q.push_back('{data: 8'h00, syn: 4'd3, sec: 1'b1, ded: 1'b0});
        send_dec(13'h0004);
        drain(10);
        check("pre_rst_sec", sec_count, 2'd1);
        tb_enc_ready  = 1'b0;
        dec_out_ready = 1'b0;
        send_enc(8'h55, waits);
        send_dec(13'h0F67);
        send_dec(13'h0F77);
        check("full_dec_ready", dec_in_ready, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_dec_valid", dec_out_valid, 1'b0);
        check("mid_rst_enc_valid", enc_out_valid, 1'b0);
        check("mid_rst_counts", {sec_count, ded_count}, 4'h0);
        check("mid_rst_dec_ready", dec_in_ready, 1'b1);
        rst_n         = 1'b1;
        tb_enc_ready  = 1'b1;
        dec_out_ready = 1'b1;
        outs_before   = dec_outs;
        enc_before    = enc_outs;
        repeat (6) tick();
        check("no_stale_dec", dec_outs, outs_before);
        check("no_stale_enc", enc_outs, enc_before);

        // Random round-trip stream with random backpressure.
        chain      = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 8'($urandom);
            dec_q.push_back('{data: w, syn: 4'd0, sec: 1'b0, ded: 1'b0});
            send_enc(w, waits);
        end
        rand_ready    = 1'b0;
        gate          = 1'b1;
        dec_out_ready = 1'b1;
        drain(2000);

        // Full throughput: no stalls, last word out three cycles after acceptance.
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            w = 8'(i * 37 + 5);
            dec_q.push_back('{data: w, syn: 4'd0, sec: 1'b0, ded: 1'b0});
            send_enc(w, waits);
            stalls += waits;
        end
        check("stream_stalls", stalls, 0);
        repeat (3) tick();
        check("stream_latency", dec_q.size(), 0);
        drain(20);
        chain = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
